// File: rtl/factorial_job_sequencer_pkg.sv
// factorial_job_sequencer_pkg
// Shared definitions for the factorial job sequencer: bus widths, factorial
// core register offsets, the sequencer state encoding and an address helper.
package factorial_job_sequencer_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 16;

  // Register offsets inside the factorial core window
  localparam logic [ADDR_W-1:0] OFS_OPSTART  = 16'h0000;
  localparam logic [ADDR_W-1:0] OFS_OPCLEAR  = 16'h0008;
  localparam logic [ADDR_W-1:0] OFS_INTR_EN  = 16'h0018;
  localparam logic [ADDR_W-1:0] OFS_OPERAND  = 16'h0020;
  localparam logic [ADDR_W-1:0] OFS_RESULT_H = 16'h0028;
  localparam logic [ADDR_W-1:0] OFS_RESULT_L = 16'h0030;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_REQ      = 4'd1,
    S_W_IEN    = 4'd2,
    S_W_OPND   = 4'd3,
    S_W_CLR1   = 4'd4,
    S_W_CLR0   = 4'd5,
    S_W_START  = 4'd6,
    S_WAIT_INT = 4'd7,
    S_REQ2     = 4'd8,
    S_R_HI     = 4'd9,
    S_R_LO     = 4'd10,
    S_R_CAP    = 4'd11,
    S_C_CLR1   = 4'd12,
    S_C_CLR0   = 4'd13,
    S_OUT      = 4'd14
  } seq_state_t;

  function automatic logic [ADDR_W-1:0] reg_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [ADDR_W-1:0] ofs);
    return base + ofs;
  endfunction

endpackage

// File: rtl/factorial_job_sequencer_fifo.sv
// seq_job_fifo
// Synchronous DEPTH x WIDTH job FIFO with first-word fall-through read data.
// Ports:
//   clk, reset        clock, synchronous active-high reset (empties the FIFO)
//   push, wr_data     write strobe and data (ignored when full)
//   pop               read strobe (ignored when empty)
//   rd_data           head entry, valid whenever empty = 0
//   full, empty       occupancy flags
module seq_job_fifo
  import factorial_job_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign rd_data = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[PTR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/factorial_job_sequencer.sv
// factorial_job_sequencer
// Bus master that runs queued factorial jobs through the memory-mapped
// factorial core: program the core, release the bus while it computes, wait
// for its interrupt, read back the 128-bit result, clear the core and hand
// the result to the client.
// Optional build macro JOB_TIMEOUT_EN: adds the timeout_err output and a
// WAIT_INT timer; a job that times out completes with result 0/0.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   job_valid/job_ready/job_operand    job input handshake (into FIFO)
//   res_valid/res_ready                result handshake
//   res_operand/res_hi/res_lo          returned operand and 128-bit result
//   m_req/m_grant                      bus arbitration
//   m_wr/m_addr/m_dout/m_din           bus access (m_din one cycle after addr)
//   interrupt                          core done, level-high
//   busy                               job in flight or queued
//   jobs_done                          completed-job count (wraps)
//   timeout_err                        sticky timeout flag (JOB_TIMEOUT_EN)
//
// state      | meaning
// IDLE       | waiting for a queued job; pops it on exit
// REQ        | bus requested for programming
// W_IEN      | write 1 to INTR_EN
// W_OPND     | write operand to OPERAND
// W_CLR1     | write 1 to OPCLEAR
// W_CLR0     | write 0 to OPCLEAR
// W_START    | write 1 to OPSTART, then release the bus
// WAIT_INT   | bus released, waiting for the core interrupt
// REQ2       | bus requested for readback
// R_HI       | read address RESULT_H
// R_LO       | read address RESULT_L, RESULT_H data arrives
// R_CAP      | RESULT_L data arrives
// C_CLR1     | write 1 to OPCLEAR
// C_CLR0     | write 0 to OPCLEAR, then release the bus
// OUT        | result offered to the client
module factorial_job_sequencer
  import factorial_job_sequencer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR      = 16'h7000,
  parameter int                DEPTH          = 4,
  parameter int                TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [DATA_W-1:0] job_operand,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_operand,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo,
  output logic              m_req,
  input  logic              m_grant,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_dout,
  input  logic [DATA_W-1:0] m_din,
  input  logic              interrupt,
  output logic              busy,
  output logic [CNT_W-1:0]  jobs_done
`ifdef JOB_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  localparam logic [ADDR_W-1:0] A_OPSTART  = reg_addr(BASE_ADDR, OFS_OPSTART);
  localparam logic [ADDR_W-1:0] A_OPCLEAR  = reg_addr(BASE_ADDR, OFS_OPCLEAR);
  localparam logic [ADDR_W-1:0] A_INTR_EN  = reg_addr(BASE_ADDR, OFS_INTR_EN);
  localparam logic [ADDR_W-1:0] A_OPERAND  = reg_addr(BASE_ADDR, OFS_OPERAND);
  localparam logic [ADDR_W-1:0] A_RESULT_H = reg_addr(BASE_ADDR, OFS_RESULT_H);
  localparam logic [ADDR_W-1:0] A_RESULT_L = reg_addr(BASE_ADDR, OFS_RESULT_L);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("factorial_job_sequencer: DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
  end

  seq_state_t        state;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_data;
  logic [DATA_W-1:0] cap_data;
  // Set for the one cycle in which RESULT_H read data is on m_din
  logic              cap_hi;

`ifdef JOB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             timed_out;
`endif

  assign job_ready = !fifo_full && !reset;
  assign fifo_push = job_valid && job_ready;
  assign fifo_pop  = (state == S_IDLE) && !fifo_empty;
  assign busy      = (state != S_IDLE) || !fifo_empty;

  always_comb begin
    cap_data = m_din;
`ifdef JOB_TIMEOUT_EN
    if (timed_out) begin
      cap_data = '0;
    end
`endif
  end

  seq_job_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .wr_data (job_operand),
    .pop     (fifo_pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Bus outputs are loaded on the edge that enters an access state, so each
  // access is presented for as long as the state is held; a state only
  // advances on a granted cycle, which stalls cleanly when grant drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      m_req       <= 1'b0;
      m_wr        <= 1'b0;
      m_addr      <= '0;
      m_dout      <= '0;
      res_valid   <= 1'b0;
      res_operand <= '0;
      res_hi      <= '0;
      res_lo      <= '0;
      jobs_done   <= '0;
      cap_hi      <= 1'b0;
`ifdef JOB_TIMEOUT_EN
      tmo_cnt     <= '0;
      timed_out   <= 1'b0;
      timeout_err <= 1'b0;
`endif
    end else begin
      cap_hi <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            state       <= S_REQ;
            m_req       <= 1'b1;
            res_operand <= fifo_data;
          end
        end
        S_REQ: begin
          if (m_grant) begin
            state  <= S_W_IEN;
            m_wr   <= 1'b1;
            m_addr <= A_INTR_EN;
            m_dout <= 64'd1;
          end
        end
        S_W_IEN: begin
          if (m_grant) begin
            state  <= S_W_OPND;
            m_addr <= A_OPERAND;
            m_dout <= res_operand;
          end
        end
        S_W_OPND: begin
          if (m_grant) begin
            state  <= S_W_CLR1;
            m_addr <= A_OPCLEAR;
            m_dout <= 64'd1;
          end
        end
        S_W_CLR1: begin
          if (m_grant) begin
            state  <= S_W_CLR0;
            m_dout <= 64'd0;
          end
        end
        S_W_CLR0: begin
          if (m_grant) begin
            state  <= S_W_START;
            m_addr <= A_OPSTART;
            m_dout <= 64'd1;
          end
        end
        S_W_START: begin
          if (m_grant) begin
            state     <= S_WAIT_INT;
            m_req     <= 1'b0;
            m_wr      <= 1'b0;
            m_addr    <= '0;
`ifdef JOB_TIMEOUT_EN
            tmo_cnt   <= TMO_W'(TIMEOUT_CYCLES - 1);
            timed_out <= 1'b0;
`endif
          end
        end
        S_WAIT_INT: begin
          if (interrupt) begin
            state <= S_REQ2;
            m_req <= 1'b1;
          end
`ifdef JOB_TIMEOUT_EN
          else if (tmo_cnt == '0) begin
            state       <= S_REQ2;
            m_req       <= 1'b1;
            timed_out   <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
`endif
        end
        S_REQ2: begin
          if (m_grant) begin
            state  <= S_R_HI;
            m_wr   <= 1'b0;
            m_addr <= A_RESULT_H;
          end
        end
        S_R_HI: begin
          if (m_grant) begin
            state  <= S_R_LO;
            m_addr <= A_RESULT_L;
            cap_hi <= 1'b1;
          end
        end
        S_R_LO: begin
          if (cap_hi) begin
            res_hi <= cap_data;
          end
          if (m_grant) begin
            state  <= S_R_CAP;
            m_addr <= '0;
          end
        end
        S_R_CAP: begin
          // Entered only after a granted RESULT_L address cycle
          res_lo <= cap_data;
          state  <= S_C_CLR1;
          m_wr   <= 1'b1;
          m_addr <= A_OPCLEAR;
          m_dout <= 64'd1;
        end
        S_C_CLR1: begin
          if (m_grant) begin
            state  <= S_C_CLR0;
            m_dout <= 64'd0;
          end
        end
        S_C_CLR0: begin
          if (m_grant) begin
            state     <= S_OUT;
            m_req     <= 1'b0;
            m_wr      <= 1'b0;
            m_addr    <= '0;
            res_valid <= 1'b1;
          end
        end
        S_OUT: begin
          if (res_ready) begin
            state     <= S_IDLE;
            res_valid <= 1'b0;
            jobs_done <= jobs_done + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          m_req <= 1'b0;
          m_wr  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_factorial_job_sequencer.sv
`timescale 1ns/1ps
module tb_factorial_job_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [63:0] job_operand = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [63:0] res_operand, res_hi, res_lo;
  logic        m_req;
  logic        m_grant = 1'b1;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [63:0] m_dout;
  logic [63:0] m_din = '0;
  logic        interrupt;
  logic        busy;
  logic [15:0] jobs_done;
`ifdef JOB_TIMEOUT_EN
  logic        timeout_err;
`endif

  int errors = 0;
  int checks = 0;

  // Core model state
  logic        ien = 1'b0;
  logic        irq = 1'b0;
  int          cnt = 0;
  int          core_delay = 5;
  logic        core_dead = 1'b0;
  logic        model_clr = 1'b0;
  logic [63:0] opnd = '0;
  logic [63:0] f_hi = '0, f_lo = '0;

  // Bus write log
  logic [15:0] wa [$];
  logic [63:0] wd [$];

  logic [15:0] exp_a [7] = '{16'h7018, 16'h7020, 16'h7008, 16'h7008, 16'h7000, 16'h7008, 16'h7008};
  logic [63:0] exp_d [7] = '{64'd1, 64'd0, 64'd1, 64'd0, 64'd1, 64'd1, 64'd0};
  logic [63:0] b_op  [4] = '{64'd6, 64'd7, 64'd8, 64'd3};
  logic [63:0] b_lo  [4] = '{64'd720, 64'd5040, 64'd40320, 64'd6};

  assign interrupt = irq;

  always #5 clk = ~clk;

  factorial_job_sequencer #(
    .BASE_ADDR      (16'h7000),
    .DEPTH          (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .job_valid   (job_valid),
    .job_ready   (job_ready),
    .job_operand (job_operand),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_operand (res_operand),
    .res_hi      (res_hi),
    .res_lo      (res_lo),
    .m_req       (m_req),
    .m_grant     (m_grant),
    .m_wr        (m_wr),
    .m_addr      (m_addr),
    .m_dout      (m_dout),
    .m_din       (m_din),
    .interrupt   (interrupt),
    .busy        (busy),
    .jobs_done   (jobs_done)
`ifdef JOB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  function automatic logic [127:0] fact(input logic [63:0] n);
    logic [127:0] r;
    r = 128'd1;
    for (int i = 2; i <= int'(n); i++) r = r * 128'(i);
    return r;
  endfunction

  // Factorial core: granted writes program it, OPSTART launches a computation
  // that raises a level interrupt core_delay cycles later, OPCLEAR drops it.
  always @(posedge clk) begin
    if (model_clr) begin
      irq <= 1'b0;
      cnt <= 0;
    end else begin
      if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1 && ien && !core_dead) irq <= 1'b1;
      end
      if (m_req && m_grant && m_wr) begin
        case (m_addr)
          16'h7018: ien <= m_dout[0];
          16'h7020: opnd <= m_dout;
          16'h7008: if (m_dout[0]) begin irq <= 1'b0; cnt <= 0; end
          16'h7000: if (m_dout[0]) begin
            {f_hi, f_lo} <= fact(opnd);
            cnt <= core_delay;
          end
          default: ;
        endcase
      end
    end
    if (m_grant && !m_wr && m_addr == 16'h7028) m_din <= f_hi;
    else if (m_grant && !m_wr && m_addr == 16'h7030) m_din <= f_lo;
    else m_din <= 64'hBAD0_BAD0_BAD0_BAD0;
  end

  always @(posedge clk) begin
    if (m_req && m_grant && m_wr) begin
      wa.push_back(m_addr);
      wd.push_back(m_dout);
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_job(input logic [63:0] op);
    job_valid   = 1'b1;
    job_operand = op;
    @(negedge clk);
    job_valid   = 1'b0;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic wait_res(input int lim);
    int n = 0;
    while (!res_valid && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("res_valid_wait", res_valid, 1);
  endtask

  task automatic wait_addr(input logic [15:0] a, input int lim);
    int n = 0;
    while (m_addr !== a && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("addr_wait", m_addr, a);
  endtask

  task automatic wait_log(input int cnt_req, input int lim);
    int n = 0;
    while (wa.size() < cnt_req && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("log_wait", wa.size() >= cnt_req, 1);
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  task automatic check_log(input logic [63:0] op);
    logic [63:0] d;
    check("log_len", wa.size(), 7);
    for (int i = 0; i < 7; i++) begin
      d = (i == 1) ? op : exp_d[i];
      check($sformatf("log_addr%0d", i), (i < wa.size()) ? wa[i] : 16'hFFFF, exp_a[i]);
      check($sformatf("log_data%0d", i), (i < wd.size()) ? wd[i] : 64'hFFFF, d);
    end
  endtask

  initial begin
    int bad;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_job_ready", job_ready, 0);
    check("rst_m_req", m_req, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_jobs_done", jobs_done, 0);
    check("rst_m_addr", m_addr, 0);
`ifdef JOB_TIMEOUT_EN
    check("rst_timeout_err", timeout_err, 0);
`endif
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_job_ready", job_ready, 1);

    // Single job, operand 10
    clear_log();
    push_job(64'd10);
    wait_res(200);
    check("t1_operand", res_operand, 10);
    check("t1_hi", res_hi, 0);
    check("t1_lo", res_lo, 3628800);
    check_log(64'd10);
    handshake();
    check("t1_jobs_done", jobs_done, 1);
    check("t1_valid_drop", res_valid, 0);

    // Back-to-back jobs, fill the FIFO, hold off the first result
    push_job(64'd5);
    push_job(64'd6);
    push_job(64'd7);
    push_job(64'd8);
    check("fifo3_ready", job_ready, 1);
    push_job(64'd3);
    check("fifo_full_ready", job_ready, 0);
    job_valid   = 1'b1;
    job_operand = 64'd9;
    repeat (3) @(negedge clk);
    job_valid = 1'b0;
    check("fifo_full_ready2", job_ready, 0);

    wait_res(200);
    check("t2_op5", res_operand, 5);
    check("t2_lo5", res_lo, 120);
    check("t2_hi5", res_hi, 0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (res_lo !== 64'd120 || res_hi !== 64'd0 || res_operand !== 64'd5 ||
          res_valid !== 1'b1 || m_req !== 1'b0) bad++;
    end
    check("hold_stable", bad, 0);
    handshake();
    check("hs_valid_drop", res_valid, 0);
    check("hs_idle_req", m_req, 0);
    @(negedge clk);
    check("next_job_req", m_req, 1);
    for (int i = 0; i < 4; i++) begin
      wait_res(200);
      check($sformatf("t2_op%0d", i), res_operand, b_op[i]);
      check($sformatf("t2_lo%0d", i), res_lo, b_lo[i]);
      check($sformatf("t2_hi%0d", i), res_hi, 0);
      handshake();
    end
    repeat (5) @(negedge clk);
    check("t2_busy_done", busy, 0);
    check("t2_jobs_done", jobs_done, 6);

    // Grant withheld during the OPERAND write
    clear_log();
    push_job(64'd4);
    wait_addr(16'h7020, 50);
    m_grant = 1'b0;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (m_addr !== 16'h7020 || m_dout !== 64'd4 || m_wr !== 1'b1) bad++;
    end
    check("stall_hold", bad, 0);
    check("stall_no_write", wa.size(), 1);
    m_grant = 1'b1;
    wait_res(200);
    check("t3_lo", res_lo, 24);
    check_log(64'd4);
    handshake();
    check("t3_jobs_done", jobs_done, 7);

    // Reset while waiting for the interrupt
    clear_log();
    core_delay = 30;
    push_job(64'd9);
    push_job(64'd2);
    wait_log(5, 100);
    check("wi_req_low", m_req, 0);
    reset = 1'b1;
    @(negedge clk);
    check("mr_m_req", m_req, 0);
    check("mr_m_addr", m_addr, 0);
    check("mr_m_wr", m_wr, 0);
    check("mr_m_dout", m_dout, 0);
    check("mr_res_valid", res_valid, 0);
    check("mr_res_operand", res_operand, 0);
    check("mr_busy", busy, 0);
    check("mr_jobs_done", jobs_done, 0);
    check("mr_job_ready", job_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    check("mr_job_ready_rel", job_ready, 1);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (m_req !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("mr_quiet", bad, 0);
    check("mr_no_clear", wa.size(), 5);

`ifdef JOB_TIMEOUT_EN
    // Core never interrupts: timer forces readback with zero result
    core_dead = 1'b1;
    model_clr = 1'b1;
    @(negedge clk);
    model_clr = 1'b0;
    core_delay = 5;
    clear_log();
    push_job(64'd11);
    wait_res(400);
    check("to_err", timeout_err, 1);
    check("to_hi", res_hi, 0);
    check("to_lo", res_lo, 0);
    check("to_operand", res_operand, 11);
    check_log(64'd11);
    handshake();
    check("to_jobs_done", jobs_done, 1);
    check("to_sticky", timeout_err, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
